// File: rtl/demux_pkg.sv
// Shared types for the 4-slot TDM demultiplexer.
package demux_pkg;
  localparam int NUM_SLOTS = 4;
  typedef logic [1:0] slot_t;
  typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_e;
endpackage

// File: rtl/demux_sync_ctl.sv
// Frame alignment FSM and slot counter: decides which shadow slot a beat fills,
// when a frame completes, and flags framing violations.
module demux_sync_ctl
  import demux_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  din_valid_i,
  input  logic  fsync_i,
  output logic  wr_en_o,
  output slot_t wr_idx_o,
  output logic  frame_done_o,
  output logic  sync_err_o,
  output logic  locked_o,
  output slot_t slot_sel_o
);
  state_e state_q, state_d;
  slot_t  cnt_q, cnt_d;
  logic   viol;
  logic   sync_err_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wr_en_o      = 1'b0;
    wr_idx_o     = cnt_q;
    frame_done_o = 1'b0;
    viol         = 1'b0;
    if (din_valid_i) begin
      case (state_q)
        HUNT: if (fsync_i) begin
          wr_en_o  = 1'b1;
          wr_idx_o = '0;
          cnt_d    = 2'd1;
          state_d  = LOCK;
        end
        LOCK: begin
          if (fsync_i) begin
            // Early sync restarts the frame on this beat; stale slots get overwritten.
            viol     = (cnt_q != 2'd0);
            wr_en_o  = 1'b1;
            wr_idx_o = '0;
            cnt_d    = 2'd1;
          end else if (cnt_q == 2'd0) begin
            viol    = 1'b1;
            state_d = HUNT;
          end else if (cnt_q == 2'd3) begin
            frame_done_o = 1'b1;
            cnt_d        = 2'd0;
          end else begin
            wr_en_o = 1'b1;
            cnt_d   = cnt_q + 2'd1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HUNT;
      cnt_q      <= '0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sync_err_q <= viol;
    end
  end

  assign sync_err_o = sync_err_q;
  assign locked_o   = (state_q == LOCK);
  assign slot_sel_o = cnt_q;
endmodule

// File: rtl/demux_14.sv
// Registered 1-to-4 TDM demux: shadows slots 0..2, then publishes all four
// channels together with a one-cycle frame strobe on the slot-3 beat.
module demux_14
  import demux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             fsync,
  output logic [WIDTH-1:0] ch_a,
  output logic [WIDTH-1:0] ch_b,
  output logic [WIDTH-1:0] ch_c,
  output logic [WIDTH-1:0] ch_d,
  output logic             frame_valid,
  output logic [1:0]       slot_sel,
  output logic             locked,
  output logic             sync_err
);
  logic                                wr_en, frame_done;
  slot_t                               wr_idx;
  logic [NUM_SLOTS-2:0][WIDTH-1:0]     shadow_q;

  demux_sync_ctl u_ctl (
    .clk          (clk),
    .rst_n        (rst_n),
    .din_valid_i  (din_valid),
    .fsync_i      (fsync),
    .wr_en_o      (wr_en),
    .wr_idx_o     (wr_idx),
    .frame_done_o (frame_done),
    .sync_err_o   (sync_err),
    .locked_o     (locked),
    .slot_sel_o   (slot_sel)
  );

  // Slot 3 is never shadowed: it goes straight to ch_d on the completing edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q    <= '0;
      ch_a        <= '0;
      ch_b        <= '0;
      ch_c        <= '0;
      ch_d        <= '0;
      frame_valid <= 1'b0;
    end else begin
      for (int s = 0; s < NUM_SLOTS-1; s++)
        if (wr_en && wr_idx == slot_t'(s)) shadow_q[s] <= din;
      frame_valid <= frame_done;
      if (frame_done) begin
        ch_a <= shadow_q[0];
        ch_b <= shadow_q[1];
        ch_c <= shadow_q[2];
        ch_d <= din;
      end
    end
  end
endmodule
